// File: rtl/serial_eq_compare_ctrl_if.sv
// Bundle of the request, comparator and result signals of serial_eq_compare_ctrl.
// slave  : the controller side.
// master : the requester / comparator side.
interface serial_eq_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Request handshake: a request is accepted on a rising edge where
  // Start_SI=1 and Ready_SO=1. Result handshake: a result is consumed on a
  // rising edge where Valid_SO=1 and Ack_SI=1. Start_SI is ignored while
  // Ready_SO=0 and Ack_SI is ignored while Valid_SO=0.
  logic             Start_SI;
  logic             Ready_SO;
  logic [WIDTH-1:0] A_DI;
  logic [WIDTH-1:0] B_DI;
  logic             BitA_DO;
  logic             BitB_DO;
  logic             BitEn_SO;
  logic             BitEq_DI;
  logic             Valid_SO;
  logic             Ack_SI;
  logic             Equal_DO;
  logic [IDX_W-1:0] MismatchIdx_DO;
  logic [CNT_W-1:0] MismatchCnt_DO;

  modport slave (
    input  Start_SI, A_DI, B_DI, BitEq_DI, Ack_SI,
    output Ready_SO, BitA_DO, BitB_DO, BitEn_SO, Valid_SO,
           Equal_DO, MismatchIdx_DO, MismatchCnt_DO
  );

  modport master (
    output Start_SI, A_DI, B_DI, BitEq_DI, Ack_SI,
    input  Ready_SO, BitA_DO, BitB_DO, BitEn_SO, Valid_SO,
           Equal_DO, MismatchIdx_DO, MismatchCnt_DO
  );
endinterface

// File: rtl/serial_eq_compare_ctrl.sv
// Bit-serial WIDTH-bit equality compare using one shared external 1-bit
// comparator, LSB first. Returns equal flag, lowest mismatch index and
// mismatch count through a valid/ack result handshake.
module serial_eq_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  serial_eq_compare_ctrl_if.slave   bus,
  output logic [1:0]                DbgState_SO
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // Working accumulators, live only during COMPARE.
  logic             eq_q, eq_d;
  logic [IDX_W-1:0] midx_q, midx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Published result; changes only on the edge that leaves COMPARE, so the
  // previous result stays visible until the next one is ready.
  logic             res_eq_q, res_eq_d;
  logic [IDX_W-1:0] res_midx_q, res_midx_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             mism;
  logic             eq_nxt;
  logic [IDX_W-1:0] midx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;

  // Per-bit accumulate values for the bit currently on the comparator.
  always_comb begin
    mism     = ~bus.BitEq_DI;
    last_bit = (idx_q == LAST_IDX);
    eq_nxt   = eq_q & ~mism;
    midx_nxt = (mism && eq_q) ? idx_q : midx_q;
    cnt_nxt  = cnt_q + CNT_W'(mism);
  end

  // Next-state logic for the sequencer and its datapath.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    eq_d       = eq_q;
    midx_d     = midx_q;
    cnt_d      = cnt_q;
    res_eq_d   = res_eq_q;
    res_midx_d = res_midx_q;
    res_cnt_d  = res_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start_SI) begin
          a_d     = bus.A_DI;
          b_d     = bus.B_DI;
          idx_d   = '0;
          eq_d    = 1'b1;
          midx_d  = '0;
          cnt_d   = '0;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        eq_d   = eq_nxt;
        midx_d = midx_nxt;
        cnt_d  = cnt_nxt;
        if ((EARLY_EXIT && mism) || last_bit) begin
          res_eq_d   = eq_nxt;
          res_midx_d = midx_nxt;
          res_cnt_d  = cnt_nxt;
          state_d    = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.Ack_SI) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      eq_q       <= 1'b0;
      midx_q     <= '0;
      cnt_q      <= '0;
      res_eq_q   <= 1'b0;
      res_midx_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      eq_q       <= eq_d;
      midx_q     <= midx_d;
      cnt_q      <= cnt_d;
      res_eq_q   <= res_eq_d;
      res_midx_q <= res_midx_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  // Outputs decoded from registered state only; bit pair comes from the
  // captured operands, never from A_DI/B_DI.
  always_comb begin
    bus.Ready_SO       = (state_q == ST_IDLE);
    bus.BitEn_SO       = (state_q == ST_COMPARE);
    bus.Valid_SO       = (state_q == ST_DONE);
    bus.BitA_DO        = (state_q == ST_COMPARE) ? a_q[idx_q] : 1'b0;
    bus.BitB_DO        = (state_q == ST_COMPARE) ? b_q[idx_q] : 1'b0;
    bus.Equal_DO       = res_eq_q;
    bus.MismatchIdx_DO = res_midx_q;
    bus.MismatchCnt_DO = res_cnt_q;
    DbgState_SO        = state_q;
  end
endmodule

// File: tb/tb_serial_eq_compare_ctrl.sv
// Directed bench: two controllers (EARLY_EXIT=0 and EARLY_EXIT=1) driven with
// identical requests, each with its own ideal 1-bit comparator.
module tb_serial_eq_compare_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic [1:0] dbg0, dbg1;

  int n_tests = 0;
  int n_fail  = 0;

  serial_eq_compare_ctrl_if #(.WIDTH(W)) if0 ();
  serial_eq_compare_ctrl_if #(.WIDTH(W)) if1 ();

  serial_eq_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .bus(if0), .DbgState_SO(dbg0)
  );
  serial_eq_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .bus(if1), .DbgState_SO(dbg1)
  );

  // Shared request stimulus
  logic         start, ack;
  logic [W-1:0] a_in, b_in;

  assign if0.Start_SI = start;  assign if1.Start_SI = start;
  assign if0.Ack_SI   = ack;    assign if1.Ack_SI   = ack;
  assign if0.A_DI     = a_in;   assign if1.A_DI     = a_in;
  assign if0.B_DI     = b_in;   assign if1.B_DI     = b_in;
  // Ideal external comparators
  assign if0.BitEq_DI = ~(if0.BitA_DO ^ if0.BitB_DO);
  assign if1.BitEq_DI = ~(if1.BitA_DO ^ if1.BitB_DO);

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results collected by wait_result
  int          cyc0, cyc1;
  logic [15:0] bits0;
  logic        timed_out;

  // Drive one request so it is accepted at the next rising edge (E0).
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = W'($urandom_range(0, 255));
    b_in  = W'($urandom_range(0, 255));
  endtask

  // Count BitEn cycles per controller until both show Valid; record A bits
  // driven by the EARLY_EXIT=0 controller.
  task automatic wait_result();
    cyc0 = 0; cyc1 = 0; bits0 = '0; timed_out = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if0.Valid_SO && if1.Valid_SO) return;
      if (!if0.Valid_SO && if0.BitEn_SO) begin
        if (cyc0 < 16) bits0[cyc0] = if0.BitA_DO;
        cyc0++;
      end
      if (!if1.Valid_SO && if1.BitEn_SO) cyc1++;
    end
    timed_out = 1'b1;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({if0.Ready_SO, if0.Valid_SO, if0.BitEn_SO, if0.BitA_DO, if0.BitB_DO, if0.Equal_DO,
         if0.MismatchIdx_DO, if0.MismatchCnt_DO, dbg0} !== {6'b100000, 3'd0, 4'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_ee0 got rdy=%b vld=%b en=%b eq=%b idx=%0d cnt=%0d st=%0d want rdy=1 rest 0",
               if0.Ready_SO, if0.Valid_SO, if0.BitEn_SO, if0.Equal_DO, if0.MismatchIdx_DO,
               if0.MismatchCnt_DO, dbg0);
    end
    n_tests++;
    if ({if1.Ready_SO, if1.Valid_SO, if1.BitEn_SO, if1.BitA_DO, if1.BitB_DO, if1.Equal_DO,
         if1.MismatchIdx_DO, if1.MismatchCnt_DO, dbg1} !== {6'b100000, 3'd0, 4'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_ee1 got rdy=%b vld=%b en=%b eq=%b idx=%0d cnt=%0d st=%0d want rdy=1 rest 0",
               if1.Ready_SO, if1.Valid_SO, if1.BitEn_SO, if1.Equal_DO, if1.MismatchIdx_DO,
               if1.MismatchCnt_DO, dbg1);
    end
    rst_n = 1'b1;
  endtask

  // Both controllers: equal operands scan all 8 bits.
  task automatic test_equal();
    do_start(8'hA5, 8'hA5);
    @(negedge clk);
    n_tests++;
    if (if1.Ready_SO !== 1'b0 || if1.BitEn_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL equal_busy got rdy=%b en=%b want rdy=0 en=1", if1.Ready_SO, if1.BitEn_SO);
    end
    wait_result();
    cyc0++; cyc1++;  // account for the cycle consumed above
    n_tests++;
    if (timed_out || cyc0 !== 8 || cyc1 !== 8) begin
      n_fail++;
      $display("FAIL equal_latency got to=%b c0=%0d c1=%0d want 8 8", timed_out, cyc0, cyc1);
    end
    n_tests++;
    if ({if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO} !== {1'b1, 3'd0, 4'd0} ||
        {if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO} !== {1'b1, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL equal_result got ee0 %b/%0d/%0d ee1 %b/%0d/%0d want 1/0/0",
               if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO,
               if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO);
    end
    do_ack();
  endtask

  // LSB mismatch: early exit after one bit.
  task automatic test_lsb_mismatch();
    do_start(8'hA5, 8'hA4);
    wait_result();
    n_tests++;
    if (timed_out || cyc0 !== 8 || cyc1 !== 1) begin
      n_fail++;
      $display("FAIL lsb_latency got to=%b c0=%0d c1=%0d want 8 1", timed_out, cyc0, cyc1);
    end
    n_tests++;
    if ({if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO} !== {1'b0, 3'd0, 4'd1} ||
        {if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO} !== {1'b0, 3'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL lsb_result got ee0 %b/%0d/%0d ee1 %b/%0d/%0d want 0/0/1",
               if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO,
               if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO);
    end
    do_ack();
  endtask

  // MSB mismatch: last index, bit order LSB first.
  task automatic test_msb_mismatch();
    do_start(8'h80, 8'h00);
    wait_result();
    n_tests++;
    if (timed_out || cyc0 !== 8 || cyc1 !== 8) begin
      n_fail++;
      $display("FAIL msb_latency got to=%b c0=%0d c1=%0d want 8 8", timed_out, cyc0, cyc1);
    end
    n_tests++;
    if (bits0 !== 16'h0080) begin
      n_fail++;
      $display("FAIL msb_bit_order got %h want 0080", bits0);
    end
    n_tests++;
    if ({if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO} !== {1'b0, 3'd7, 4'd1} ||
        {if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO} !== {1'b0, 3'd7, 4'd1}) begin
      n_fail++;
      $display("FAIL msb_result got ee0 %b/%0d/%0d ee1 %b/%0d/%0d want 0/7/1",
               if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO,
               if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO);
    end
    do_ack();
  endtask

  // Several mismatches: full scan counts 4, early exit stops at bit 4.
  task automatic test_multi_mismatch();
    do_start(8'hFF, 8'h0F);
    wait_result();
    n_tests++;
    if (timed_out || cyc0 !== 8 || cyc1 !== 5) begin
      n_fail++;
      $display("FAIL multi_latency got to=%b c0=%0d c1=%0d want 8 5", timed_out, cyc0, cyc1);
    end
    n_tests++;
    if ({if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO} !== {1'b0, 3'd4, 4'd4}) begin
      n_fail++;
      $display("FAIL multi_result_ee0 got %b/%0d/%0d want 0/4/4",
               if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO);
    end
    n_tests++;
    if ({if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO} !== {1'b0, 3'd4, 4'd1}) begin
      n_fail++;
      $display("FAIL multi_result_ee1 got %b/%0d/%0d want 0/4/1",
               if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO);
    end
    do_ack();
  endtask

  // All bits differ (count reaches WIDTH); hold with Ack low while inputs
  // churn; Start coincident with Ack ignored; then the next request runs.
  task automatic test_hold_ack();
    do_start(8'h0F, 8'hF0);
    wait_result();
    n_tests++;
    if (timed_out || cyc0 !== 8 || cyc1 !== 1) begin
      n_fail++;
      $display("FAIL hold_latency got to=%b c0=%0d c1=%0d want 8 1", timed_out, cyc0, cyc1);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      start = ~start;
      a_in  = W'($urandom_range(0, 255));
      b_in  = W'($urandom_range(0, 255));
      @(negedge clk);
      n_tests++;
      if ({if0.Valid_SO, if0.Ready_SO, if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO} !==
          {3'b100, 3'd0, 4'd8} ||
          {if1.Valid_SO, if1.Ready_SO, if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO} !==
          {3'b100, 3'd0, 4'd1}) begin
        n_fail++;
        $display("FAIL hold_stable cyc %0d got ee0 v%b r%b %b/%0d/%0d ee1 v%b r%b %b/%0d/%0d want v1 r0 0/0/8 and 0/0/1",
                 k, if0.Valid_SO, if0.Ready_SO, if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO,
                 if1.Valid_SO, if1.Ready_SO, if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO);
      end
    end
    @(negedge clk);
    ack = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0; start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if0.Valid_SO !== 1'b0 || if0.Ready_SO !== 1'b1 || if1.Valid_SO !== 1'b0 ||
        if1.Ready_SO !== 1'b1 || if0.MismatchCnt_DO !== 4'd8) begin
      n_fail++;
      $display("FAIL after_ack got v%b r%b v%b r%b cnt%0d want v0 r1 v0 r1 cnt8",
               if0.Valid_SO, if0.Ready_SO, if1.Valid_SO, if1.Ready_SO, if0.MismatchCnt_DO);
    end
    do_start(8'h55, 8'h55);
    @(negedge clk);
    n_tests++;
    if (if0.BitEn_SO !== 1'b1 || if0.MismatchCnt_DO !== 4'd8) begin
      n_fail++;
      $display("FAIL next_accept got en=%b cnt=%0d want en=1 cnt=8 (old result held)",
               if0.BitEn_SO, if0.MismatchCnt_DO);
    end
    wait_result();
    n_tests++;
    if (timed_out || if0.Equal_DO !== 1'b1 || if1.Equal_DO !== 1'b1 || if0.MismatchCnt_DO !== 4'd0) begin
      n_fail++;
      $display("FAIL next_result got to=%b eq0=%b eq1=%b cnt0=%0d want 1 1 0",
               timed_out, if0.Equal_DO, if1.Equal_DO, if0.MismatchCnt_DO);
    end
    do_ack();
  endtask

  // Asynchronous reset mid-compare at idx 3, then a fresh compare.
  task automatic test_reset_mid();
    do_start(8'hFF, 8'hFF);
    repeat (2) @(posedge clk);   // E2 was the last; next is E3
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if0.Ready_SO, if0.Valid_SO, if0.BitEn_SO, if0.BitA_DO, if0.BitB_DO, if0.Equal_DO,
         if0.MismatchIdx_DO, if0.MismatchCnt_DO, dbg0} !== {6'b100000, 3'd0, 4'd0, 2'd0} ||
        {if1.Ready_SO, if1.Valid_SO, if1.BitEn_SO, if1.BitA_DO, if1.BitB_DO, if1.Equal_DO,
         if1.MismatchIdx_DO, if1.MismatchCnt_DO, dbg1} !== {6'b100000, 3'd0, 4'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_mid got r%b v%b en%b a%b b%b st%0d / r%b v%b en%b st%0d want r1 rest 0",
               if0.Ready_SO, if0.Valid_SO, if0.BitEn_SO, if0.BitA_DO, if0.BitB_DO, dbg0,
               if1.Ready_SO, if1.Valid_SO, if1.BitEn_SO, dbg1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if0.Ready_SO !== 1'b1 || if1.Ready_SO !== 1'b1 || if1.Valid_SO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got r0=%b r1=%b v1=%b want 1 1 0",
               if0.Ready_SO, if1.Ready_SO, if1.Valid_SO);
    end
    do_start(8'h12, 8'h32);
    wait_result();
    n_tests++;
    if (timed_out || cyc0 !== 8 || cyc1 !== 6 ||
        {if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO} !== {1'b0, 3'd5, 4'd1} ||
        {if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO} !== {1'b0, 3'd5, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_fresh got to=%b c0=%0d c1=%0d ee0 %b/%0d/%0d ee1 %b/%0d/%0d want 8 6 0/5/1",
               timed_out, cyc0, cyc1, if0.Equal_DO, if0.MismatchIdx_DO, if0.MismatchCnt_DO,
               if1.Equal_DO, if1.MismatchIdx_DO, if1.MismatchCnt_DO);
    end
    do_ack();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    test_reset();
    test_equal();
    test_lsb_mismatch();
    test_msb_mismatch();
    test_multi_mismatch();
    test_hold_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
